// File: rtl/cfg_chain_driver.sv
// Purpose : serialises host config words MSB-first onto the tile config chain and
//           frames them with program_mode so every tile counts exactly one frame.
// Latency : word handshake in cycle n -> first bit on data_out in cycle n+1; zero bubble
//           between words when the next word is offered on the last bit of the current one.
// Backpressure: word_ready is low while the driver is still shifting or once the frame
//           is full; a missing word inserts program_mode=0 bubbles that tiles do not count.
//
// Ports
//   clk, rst          clock (posedge) and asynchronous active-low reset
//   start, abort      start a frame (IDLE only); synchronous abort to IDLE
//   word_in/_valid    host config word and its valid
//   word_ready        driver accepts word_in this cycle
//   data_out          registered serial bit to tile 0 data_in
//   program_mode      registered broadcast strobe, high on every frame/flush bit
//   busy, done        not-IDLE indicator; one-cycle frame completion pulse
//
// WORD_W must be at least 2 and FLUSH_CYCLES at least 1.

module cfg_chain_driver #(
  parameter int NUM_OF_TILES = 4,
  parameter int MEM_CYCLES   = 4096,
  parameter int WORD_W       = 32,
  parameter int FLUSH_CYCLES = NUM_OF_TILES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              data_out,
  output logic              program_mode,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_BITS = NUM_OF_TILES * (MEM_CYCLES + 1);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int BL_W       = $clog2(WORD_W + 1);
  localparam int FL_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Value of bit_cnt while the final frame bit is being emitted.
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_BITS);
  localparam logic [BL_W-1:0]  WORD_BITS  = BL_W'(WORD_W);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [WORD_W-1:0] sreg_q,      sreg_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              data_out_q,  data_out_d;
  logic              pm_q,        pm_d;
  logic              done_q,      done_d;

  logic              handshake;
  logic [CNT_W-1:0]  bit_cnt_inc;

  // Ready in LOAD, or on the last bit of a word when the frame still needs more bits.
  // Gated by abort so a word is never consumed by a frame that is being torn down.
  always_comb begin
    word_ready = 1'b0;
    if (!abort) begin
      if (state_q == S_LOAD) begin
        word_ready = 1'b1;
      end else if (state_q == S_SHIFT &&
                   bits_left_q == BL_W'(1) &&
                   bit_cnt_q < FRAME_LAST) begin
        word_ready = 1'b1;
      end
    end
  end

  assign handshake = word_valid & word_ready;

  // Frame bit counter never wraps past a full frame.
  assign bit_cnt_inc = (bit_cnt_q == FRAME_FULL) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    data_out_d  = data_out_q;
    pm_d        = pm_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        pm_d = 1'b0;
        if (start) begin
          state_d     = S_LOAD;
          bit_cnt_d   = '0;
          bits_left_d = '0;
          flush_cnt_d = '0;
        end
      end

      S_LOAD: begin
        if (handshake) begin
          // The MSB goes straight to data_out so the first bit appears the cycle
          // after the handshake; the shift register keeps the remaining bits.
          data_out_d  = word_in[WORD_W-1];
          pm_d        = 1'b1;
          sreg_d      = word_in << 1;
          bits_left_d = WORD_BITS - BL_W'(1);
          bit_cnt_d   = bit_cnt_inc;
          state_d     = (bit_cnt_q == FRAME_LAST) ? S_FLUSH : S_SHIFT;
        end else begin
          // Bubble: tiles ignore data_in while program_mode is low, data_out holds.
          pm_d = 1'b0;
        end
      end

      S_SHIFT: begin
        data_out_d = sreg_q[WORD_W-1];
        pm_d       = 1'b1;
        bit_cnt_d  = bit_cnt_inc;
        if (bit_cnt_q == FRAME_LAST) begin
          // Frame complete: whatever is left of the current word is dropped.
          state_d = S_FLUSH;
        end else if (handshake) begin
          // Last bit of this word leaves now; the new word starts next cycle.
          sreg_d      = word_in;
          bits_left_d = WORD_BITS;
        end else begin
          sreg_d      = sreg_q << 1;
          bits_left_d = bits_left_q - BL_W'(1);
          if (bits_left_q == BL_W'(1)) begin
            state_d = S_LOAD;
          end
        end
      end

      S_FLUSH: begin
        // Trailing zeros keep program_mode up long enough for the far tiles to
        // absorb the chain skew.
        data_out_d  = 1'b0;
        pm_d        = 1'b1;
        flush_cnt_d = flush_cnt_q + FL_W'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        data_out_d = 1'b0;
        pm_d       = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        data_out_d = 1'b0;
        pm_d       = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d    = S_IDLE;
      data_out_d = 1'b0;
      pm_d       = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      bits_left_q <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      data_out_q  <= 1'b0;
      pm_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      data_out_q  <= data_out_d;
      pm_q        <= pm_d;
      done_q      <= done_d;
    end
  end

  assign data_out     = data_out_q;
  assign program_mode = pm_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfg_chain_driver.sv
module tb_cfg_chain_driver;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       word_valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] word_in = 8'h00;

  logic a_rdy, a_dat, a_pm, a_busy, a_done;
  logic b_rdy, b_dat, b_pm, b_busy, b_done;
  logic m_rdy, m_dat, m_pm, m_busy, m_done;

  // Instance A: 16-bit frame; instance B: 10-bit frame for the truncation case.
  cfg_chain_driver #(.NUM_OF_TILES(2), .MEM_CYCLES(7), .WORD_W(8), .FLUSH_CYCLES(FC)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort),
    .word_in(word_in), .word_valid(word_valid & ~sel), .word_ready(a_rdy),
    .data_out(a_dat), .program_mode(a_pm), .busy(a_busy), .done(a_done));

  cfg_chain_driver #(.NUM_OF_TILES(2), .MEM_CYCLES(4), .WORD_W(8), .FLUSH_CYCLES(FC)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort),
    .word_in(word_in), .word_valid(word_valid & sel), .word_ready(b_rdy),
    .data_out(b_dat), .program_mode(b_pm), .busy(b_busy), .done(b_done));

  assign m_rdy  = sel ? b_rdy  : a_rdy;
  assign m_dat  = sel ? b_dat  : a_dat;
  assign m_pm   = sel ? b_pm   : a_pm;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, $signed(act), $signed(req));
    end
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] w0;
    logic [7:0] w1;
    int         gap;        // ready cycles on which word 1 is withheld
    int         abort_at;   // abort after this many visible bits, -1 = never
    bit         poke;       // hold start high while busy
    int         exp_pm;
    int         exp_done;
    int         exp_done_cyc;
    int         exp_bub;
  } vec_t;

  vec_t vt[8];

  task automatic run_frame(input vec_t v, input int idx);
    bit   q[$];
    int   frame_bits;
    int   pushed = 0, wi = 0, gap_left, pm_cnt = 0, done_cnt = 0;
    int   done_cyc = -1, first = -1, last = -1, abort_k = -1;
    bit   aborted = 0;
    logic prev_dat = 1'b0;
    logic r;
    frame_bits = v.sel ? 10 : 16;
    gap_left   = v.gap;
    sel        = v.sel;
    word_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (m_pm) begin
          pm_cnt++;
          if (first < 0) first = k;
          last = k;
          if (q.size() == 0) chk($sformatf("v%0d_extra_bit_k%0d", idx, k), 1, 0);
          else chk($sformatf("v%0d_bit_k%0d", idx, k), m_dat, q.pop_front());
        end else if (first >= 0 && m_busy && !aborted) begin
          chk($sformatf("v%0d_hold_k%0d", idx, k), m_dat, prev_dat);
        end
        if (m_done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = k;
        end
        if (aborted && k == abort_k + 1)
          chk($sformatf("v%0d_after_abort", idx), {m_pm, m_dat, m_busy, m_done, m_rdy}, 0);
        prev_dat = m_dat;
      end
      start = (k == 0) || (v.poke && m_busy);
      abort = (v.abort_at >= 0) && !aborted && (pm_cnt == v.abort_at) && (first >= 0);
      if (abort) begin
        aborted = 1;
        abort_k = k;
        q.delete();
      end
      #1;
      r = m_rdy;
      word_valid = !aborted;
      word_in    = (wi == 0) ? v.w0 : (wi == 1) ? v.w1 : 8'h55;
      if (r && wi == 1 && gap_left > 0) begin
        word_valid = 1'b0;
        gap_left--;
      end
      if (pushed >= frame_bits && !aborted)
        chk($sformatf("v%0d_ready_after_full_k%0d", idx, k), r, 0);
      if (word_valid && r) begin
        for (int b = 7; b >= 0; b--) begin
          if (pushed < frame_bits) begin
            q.push_back(word_in[b]);
            pushed++;
            if (pushed == frame_bits)
              for (int f = 0; f < FC; f++) q.push_back(1'b0);
          end
        end
        wi++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
    chk($sformatf("v%0d_missing_bits", idx), q.size(), 0);
    chk($sformatf("v%0d_first_bit_cyc", idx), first, 2);
    chk($sformatf("v%0d_pm_cycles", idx), pm_cnt, v.exp_pm);
    chk($sformatf("v%0d_done_count", idx), done_cnt, v.exp_done);
    chk($sformatf("v%0d_done_cyc", idx), done_cyc, v.exp_done_cyc);
    chk($sformatf("v%0d_bubbles", idx), last - first + 1 - pm_cnt, v.exp_bub);
    chk($sformatf("v%0d_busy_end", idx), m_busy, 0);
  endtask

  initial begin
    //        sel  w0     w1     gap ab  poke pm done cyc bub
    vt[0] = '{0, 8'hA5, 8'h3C, 0, -1, 0, 18, 1, 20, 0};
    vt[1] = '{0, 8'hA5, 8'h3C, 4, -1, 0, 18, 1, 23, 3};
    vt[2] = '{0, 8'hA5, 8'h3C, 1, -1, 0, 18, 1, 20, 0};
    vt[3] = '{1, 8'hFF, 8'hC0, 0, -1, 0, 12, 1, 14, 0};
    vt[4] = '{0, 8'hA5, 8'h3C, 0,  5, 0,  5, 0, -1, 0};
    vt[5] = '{0, 8'hA5, 8'h3C, 0, -1, 1, 18, 1, 20, 0};
    vt[6] = '{0, 8'h81, 8'h7E, 2, -1, 0, 18, 1, 21, 1};
    vt[7] = '{1, 8'hFF, 8'hC0, 3, -1, 0, 12, 1, 16, 2};

    #12;
    chk("reset_outputs", {a_rdy, a_dat, a_pm, a_busy, a_done,
                          b_rdy, b_dat, b_pm, b_busy, b_done}, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(vt[i], i);

    // Asynchronous reset in the middle of a shifting frame.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    word_valid = 1'b1;
    word_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_active", {m_pm, m_busy}, 2'b11);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {m_rdy, m_dat, m_pm, m_busy, m_done}, 0);
    word_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_frame(vt[0], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
